// File: rtl/lsu_axi_ld_engine_pkg.sv
// Shared AXI constants and enums for the LSU load engine.
package lsu_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } lsu_ld_state_e;

  typedef enum logic {
    IRAM = 1'b0,
    WRAM = 1'b1
  } lsu_tgt_e;

endpackage

// File: rtl/lsu_axi_ld_engine_if.sv
// AXI read-address and read-data channels between the load engine (master) and the fabric (slave).
interface lsu_axi_ld_engine_if #(
  parameter int unsigned ID_W   = 8,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned AXI_DW = 64
);
  logic [ID_W-1:0]   lsu_axi_arid;
  logic [ADDR_W-1:0] lsu_axi_araddr;
  logic [7:0]        lsu_axi_arlen;
  logic [2:0]        lsu_axi_arsize;
  logic [1:0]        lsu_axi_arburst;
  logic              lsu_axi_arvld;
  logic              axi_lsu_arrdy;
  logic [ID_W-1:0]   axi_lsu_rid;
  logic [AXI_DW-1:0] axi_lsu_rdata;
  logic [1:0]        axi_lsu_rresp;
  logic              axi_lsu_rlast;
  logic              axi_lsu_rvld;
  logic              lsu_axi_rrdy;

  modport master (
    output lsu_axi_arid, lsu_axi_araddr, lsu_axi_arlen, lsu_axi_arsize,
           lsu_axi_arburst, lsu_axi_arvld, lsu_axi_rrdy,
    input  axi_lsu_arrdy, axi_lsu_rid, axi_lsu_rdata, axi_lsu_rresp,
           axi_lsu_rlast, axi_lsu_rvld
  );

  modport slave (
    input  lsu_axi_arid, lsu_axi_araddr, lsu_axi_arlen, lsu_axi_arsize,
           lsu_axi_arburst, lsu_axi_arvld, lsu_axi_rrdy,
    output axi_lsu_arrdy, axi_lsu_rid, axi_lsu_rdata, axi_lsu_rresp,
           axi_lsu_rlast, axi_lsu_rvld
  );
endinterface

// File: rtl/lsu_axi_ld_engine_row_pack.sv
// Packs R beats into a row, counts beats and flags rlast mismatches.
// Optional LSU_LD_RRESP_CHK_EN: non-OKAY beats are zeroed and flagged as errors.
module lsu_ld_row_pack
  import lsu_pkg::*;
#(
  parameter int unsigned AXI_DW = 64,
  parameter int unsigned ROW_W  = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              beat_vld_i,
  input  logic [AXI_DW-1:0] rdata_i,
  input  logic [1:0]        rresp_i,
  input  logic              rlast_i,
  output logic [ROW_W-1:0]  row_o,
  output logic              err_o
);

  localparam int unsigned BPR   = ROW_W / AXI_DW;
  localparam int unsigned CNT_W = $clog2(BPR + 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ROW_W-1:0]  buf_q, buf_d;
  logic [AXI_DW-1:0] beat;
  logic              resp_err;
  logic              mism;

`ifdef LSU_LD_RRESP_CHK_EN
  always_comb begin
    beat     = (rresp_i != AXI_RESP_OKAY) ? '0 : rdata_i;
    resp_err = beat_vld_i && (rresp_i != AXI_RESP_OKAY);
  end
`else
  logic unused_rresp;
  assign unused_rresp = ^rresp_i;
  always_comb begin
    beat     = rdata_i;
    resp_err = 1'b0;
  end
`endif

  // The counter saturates at BPR so surplus beats of an overlong burst are dropped, not wrapped.
  always_comb begin
    row_o = buf_q;
    for (int unsigned k = 0; k < BPR; k++) begin
      if (cnt_q == CNT_W'(k)) row_o[k*AXI_DW +: AXI_DW] = beat;
    end
    mism  = beat_vld_i && (rlast_i != (cnt_q == CNT_W'(BPR - 1)));
    err_o = mism | resp_err;

    cnt_d = cnt_q;
    buf_d = buf_q;
    if (clr_i) begin
      cnt_d = '0;
      buf_d = '0;
    end else if (beat_vld_i) begin
      if (rlast_i) begin
        cnt_d = '0;
        buf_d = '0;
      end else begin
        buf_d = row_o;
        if (cnt_q != CNT_W'(BPR)) cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      buf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      buf_q <= buf_d;
    end
  end

endmodule

// File: rtl/lsu_axi_ld_engine.sv
// LSU load engine: one INCR read burst per row, packed rows written to IRAM/WRAM with one-hot strobes.
// Optional LSU_LD_RRESP_CHK_EN enables rresp error checking in the row packer.
module lsu_axi_ld_engine
  import lsu_pkg::*;
#(
  parameter int unsigned AXI_DW  = 64,
  parameter int unsigned ROW_W   = 128,
  parameter int unsigned ROWS    = 16,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned ID_W    = 8,
  parameter int unsigned MAX_OST = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_vld,
  output logic                     cmd_rdy,
  input  logic                     cmd_tgt,
  input  logic [ADDR_W-1:0]        cmd_addr,
  input  logic [7:0]               cmd_num,
  input  logic [$clog2(ROWS)-1:0]  cmd_row0,
  lsu_axi_ld_engine_if.master      axi,
  output logic [ROWS-1:0]          lsu_mxu_iram_vld,
  output logic [ROWS-1:0]          lsu_mxu_wram_vld,
  output logic [ROW_W-1:0]         lsu_mxu_iram_pld,
  output logic [ROW_W-1:0]         lsu_mxu_wram_pld,
  output logic                     ld_done,
  output logic                     ld_err
);

  localparam int unsigned BPR   = ROW_W / AXI_DW;
  localparam int unsigned ROW_B = ROW_W / 8;
  localparam int unsigned RW    = $clog2(ROWS);

  lsu_ld_state_e     state_q, state_d;
  lsu_tgt_e          tgt_q, tgt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        num_q, num_d;
  logic [7:0]        issued_q, issued_d;
  logic [7:0]        rows_q, rows_d;
  logic [RW-1:0]     row_q, row_d;
  logic [3:0]        ost_q, ost_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic [ROWS-1:0]   iram_vld_q, iram_vld_d, wram_vld_q, wram_vld_d;
  logic [ROW_W-1:0]  iram_pld_q, iram_pld_d, wram_pld_q, wram_pld_d;

  logic             cmd_acc, ar_vld, ar_hs, r_rdy, r_hs, rl_hs, last_row;
  logic [ROW_W-1:0] row_nxt;
  logic             pk_err;
  logic             unused_rid;

  assign cmd_acc  = cmd_vld && (state_q == IDLE);
  assign ar_vld   = (state_q == RUN) && (issued_q < num_q) && (ost_q < 4'(MAX_OST));
  assign ar_hs    = ar_vld && axi.axi_lsu_arrdy;
  assign r_rdy    = (state_q == RUN);
  assign r_hs     = r_rdy && axi.axi_lsu_rvld;
  assign rl_hs    = r_hs && axi.axi_lsu_rlast;
  assign last_row = rl_hs && (rows_q == num_q - 8'd1);

  // AR payload derives only from registers that cannot change while arvld waits for arrdy.
  assign axi.lsu_axi_arid    = '0;
  assign axi.lsu_axi_araddr  = addr_q + ADDR_W'(issued_q) * ADDR_W'(ROW_B);
  assign axi.lsu_axi_arlen   = 8'(BPR - 1);
  assign axi.lsu_axi_arsize  = 3'($clog2(AXI_DW / 8));
  assign axi.lsu_axi_arburst = AXI_BURST_INCR;
  assign axi.lsu_axi_arvld   = ar_vld;
  assign axi.lsu_axi_rrdy    = r_rdy;
  assign unused_rid          = ^axi.axi_lsu_rid;

  assign cmd_rdy          = (state_q == IDLE);
  assign lsu_mxu_iram_vld = iram_vld_q;
  assign lsu_mxu_wram_vld = wram_vld_q;
  assign lsu_mxu_iram_pld = iram_pld_q;
  assign lsu_mxu_wram_pld = wram_pld_q;
  assign ld_done          = done_q;
  assign ld_err           = err_q;

  lsu_ld_row_pack #(
    .AXI_DW(AXI_DW),
    .ROW_W (ROW_W)
  ) u_row_pack (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (cmd_acc),
    .beat_vld_i(r_hs),
    .rdata_i   (axi.axi_lsu_rdata),
    .rresp_i   (axi.axi_lsu_rresp),
    .rlast_i   (axi.axi_lsu_rlast),
    .row_o     (row_nxt),
    .err_o     (pk_err)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_acc) state_d = (cmd_num == 8'd0) ? DONE : RUN;
      RUN:     if (last_row) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tgt_d      = tgt_q;
    addr_d     = addr_q;
    num_d      = num_q;
    issued_d   = issued_q;
    rows_d     = rows_q;
    row_d      = row_q;
    ost_d      = ost_q;
    err_d      = err_q;
    iram_pld_d = iram_pld_q;
    wram_pld_d = wram_pld_q;
    iram_vld_d = '0;
    wram_vld_d = '0;
    done_d     = last_row || ((state_q == DONE) && (num_q == 8'd0));

    if (cmd_acc) begin
      tgt_d    = lsu_tgt_e'(cmd_tgt);
      addr_d   = cmd_addr;
      num_d    = cmd_num;
      issued_d = '0;
      rows_d   = '0;
      row_d    = cmd_row0;
      ost_d    = '0;
      err_d    = 1'b0;
    end else begin
      if (ar_hs) issued_d = issued_q + 8'd1;
      if (ar_hs && !rl_hs) ost_d = ost_q + 4'd1;
      else if (!ar_hs && rl_hs) ost_d = ost_q - 4'd1;
      if (r_hs && pk_err) err_d = 1'b1;
      if (rl_hs) begin
        rows_d = rows_q + 8'd1;
        row_d  = row_q + RW'(1);
        if (tgt_q == IRAM) begin
          iram_vld_d = ROWS'(1) << row_q;
          iram_pld_d = row_nxt;
        end else begin
          wram_vld_d = ROWS'(1) << row_q;
          wram_pld_d = row_nxt;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tgt_q      <= IRAM;
      addr_q     <= '0;
      num_q      <= '0;
      issued_q   <= '0;
      rows_q     <= '0;
      row_q      <= '0;
      ost_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      iram_vld_q <= '0;
      wram_vld_q <= '0;
      iram_pld_q <= '0;
      wram_pld_q <= '0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      addr_q     <= addr_d;
      num_q      <= num_d;
      issued_q   <= issued_d;
      rows_q     <= rows_d;
      row_q      <= row_d;
      ost_q      <= ost_d;
      err_q      <= err_d;
      done_q     <= done_d;
      iram_vld_q <= iram_vld_d;
      wram_vld_q <= wram_vld_d;
      iram_pld_q <= iram_pld_d;
      wram_pld_q <= wram_pld_d;
    end
  end

endmodule
